mips_multicycle_ctrl_fsm: RTL

Multicycle sequencer for the MIPS processor: replaces the single-cycle opcode decoder with a Moore state machine. The FSM steps a shared-memory/shared-ALU datapath through fetch, decode, execute, memory and write-back. It supports R-type, lw, sw, beq, j and addi, and handshakes with a memory port that may insert wait states. It also keeps a retired-instruction counter.

---
 rtl/mips_multicycle_ctrl_fsm.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl_fsm.sv
// ============================================================================
// Module   : mips_multicycle_ctrl_fsm
// Brief    : Multicycle MIPS control sequencer (Moore FSM) with retire counter.
//            Optional MIPS_CTRL_ILLEGAL_TRAP_EN: unsupported opcodes trap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl_fsm (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [5:0]  i_op_code,
  input  logic        i_mem_ready,
  output logic        o_mem_req,
  output logic        o_mem_write,
  output logic        o_i_or_d,
  output logic        o_ir_write,
  output logic        o_pc_write,
  output logic        o_pc_write_cond,
  output logic [1:0]  o_pc_src,
  output logic        o_alu_src_a,
  output logic [1:0]  o_alu_src_b,
  output logic [1:0]  o_alu_op_code,
  output logic        o_reg_write,
  output logic        o_reg_dst,
  output logic        o_mem_to_reg,
  output logic [3:0]  o_state,
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  output logic        o_illegal,
`endif
  output logic [31:0] o_instr_count
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_J     = 6'b000010;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;

  state_t      r_state;
  state_t      w_next;
  logic        w_retire;
  logic        w_fetch_done;
  logic [31:0] r_instr_count;
  logic        r_illegal;

  logic        r_mem_req;
  logic        r_mem_write;
  logic        r_i_or_d;
  logic        r_pc_write;
  logic        r_pc_write_cond;
  logic [1:0]  r_pc_src;
  logic        r_alu_src_a;
  logic [1:0]  r_alu_src_b;
  logic [1:0]  r_alu_op_code;
  logic        r_reg_write;
  logic        r_reg_dst;
  logic        r_mem_to_reg;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      w_next = S_FETCH;
      S_FETCH:     w_next = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_op_code)
          C_OP_LW, C_OP_SW: w_next = S_MEM_ADDR;
          C_OP_RTYPE:       w_next = S_EXECUTE;
          C_OP_BEQ:         w_next = S_BRANCH;
          C_OP_J:           w_next = S_JUMP;
          C_OP_ADDI:        w_next = S_ADDI_EXEC;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
          default:          w_next = S_TRAP;
`else
          default:          w_next = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR:  w_next = (i_op_code == C_OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  w_next = i_mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    w_next = S_FETCH;
      S_MEM_WRITE: w_next = i_mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   w_next = S_ALU_WB;
      S_ALU_WB:    w_next = S_FETCH;
      S_BRANCH:    w_next = S_FETCH;
      S_JUMP:      w_next = S_FETCH;
      S_ADDI_EXEC: w_next = S_ADDI_WB;
      S_ADDI_WB:   w_next = S_FETCH;
      S_TRAP:      w_next = S_TRAP;
      default:     w_next = S_IDLE;
    endcase
  end

  // An illegal-opcode NOP leaves DECODE, never a retiring state, so it is never counted.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_ADDI_WB: w_retire = 1'b1;
      S_MEM_WRITE:                                     w_retire = i_mem_ready;
      default:                                         w_retire = 1'b0;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_instr_count   <= 32'd0;
      r_illegal       <= 1'b0;
      r_mem_req       <= 1'b0;
      r_mem_write     <= 1'b0;
      r_i_or_d        <= 1'b0;
      r_pc_write      <= 1'b0;
      r_pc_write_cond <= 1'b0;
      r_pc_src        <= 2'b00;
      r_alu_src_a     <= 1'b0;
      r_alu_src_b     <= 2'b00;
      r_alu_op_code   <= 2'b00;
      r_reg_write     <= 1'b0;
      r_reg_dst       <= 1'b0;
      r_mem_to_reg    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire) begin
        r_instr_count <= r_instr_count + 32'd1;
      end
      if (w_next == S_TRAP) begin
        r_illegal <= 1'b1;
      end

      r_mem_req       <= 1'b0;
      r_mem_write     <= 1'b0;
      r_i_or_d        <= 1'b0;
      r_pc_write      <= 1'b0;
      r_pc_write_cond <= 1'b0;
      r_pc_src        <= 2'b00;
      r_alu_src_a     <= 1'b0;
      r_alu_src_b     <= 2'b00;
      r_alu_op_code   <= 2'b00;
      r_reg_write     <= 1'b0;
      r_reg_dst       <= 1'b0;
      r_mem_to_reg    <= 1'b0;
      case (w_next)
        S_FETCH: begin
          r_mem_req   <= 1'b1;
          r_alu_src_b <= 2'b01;
        end
        S_DECODE: begin
          r_alu_src_b <= 2'b11;
        end
        S_MEM_ADDR, S_ADDI_EXEC: begin
          r_alu_src_a <= 1'b1;
          r_alu_src_b <= 2'b10;
        end
        S_MEM_READ: begin
          r_mem_req <= 1'b1;
          r_i_or_d  <= 1'b1;
        end
        S_MEM_WB: begin
          r_reg_write  <= 1'b1;
          r_mem_to_reg <= 1'b1;
        end
        S_MEM_WRITE: begin
          r_mem_req   <= 1'b1;
          r_mem_write <= 1'b1;
          r_i_or_d    <= 1'b1;
        end
        S_EXECUTE: begin
          r_alu_src_a   <= 1'b1;
          r_alu_op_code <= 2'b10;
        end
        S_ALU_WB: begin
          r_reg_write <= 1'b1;
          r_reg_dst   <= 1'b1;
        end
        S_BRANCH: begin
          r_alu_src_a     <= 1'b1;
          r_alu_op_code   <= 2'b01;
          r_pc_write_cond <= 1'b1;
          r_pc_src        <= 2'b01;
        end
        S_JUMP: begin
          r_pc_write <= 1'b1;
          r_pc_src   <= 2'b10;
        end
        S_ADDI_WB: begin
          r_reg_write <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // IR/PC load in FETCH must track the handshake within the same cycle.
  assign w_fetch_done    = (r_state == S_FETCH) && i_mem_ready;

  assign o_mem_req       = r_mem_req;
  assign o_mem_write     = r_mem_write;
  assign o_i_or_d        = r_i_or_d;
  assign o_ir_write      = w_fetch_done;
  assign o_pc_write      = r_pc_write | w_fetch_done;
  assign o_pc_write_cond = r_pc_write_cond;
  assign o_pc_src        = r_pc_src;
  assign o_alu_src_a     = r_alu_src_a;
  assign o_alu_src_b     = r_alu_src_b;
  assign o_alu_op_code   = r_alu_op_code;
  assign o_reg_write     = r_reg_write;
  assign o_reg_dst       = r_reg_dst;
  assign o_mem_to_reg    = r_mem_to_reg;
  assign o_state         = r_state;
  assign o_instr_count   = r_instr_count;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
  assign o_illegal       = r_illegal;
`else
  logic w_unused_illegal;
  assign w_unused_illegal = r_illegal;
`endif

endmodule

`default_nettype wire
